// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_ctrl
// Purpose  : Bit-serial ALU sequencer. Each clock it drives one 1-bit MIPS
//            style ALU slice (Ainvert/Bnegate/carry_in/less/operation), LSB
//            first. It collects the result bits, captures set/overflow on the
//            MSB cycle, and runs an extra SLT fix-up cycle when needed.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int               c_CW     = $clog2(WIDTH);
  localparam logic [c_CW-1:0]  c_LAST   = c_CW'(WIDTH - 1);

  localparam logic [3:0] c_OP_AND = 4'b0000;
  localparam logic [3:0] c_OP_OR  = 4'b0001;
  localparam logic [3:0] c_OP_ADD = 4'b0010;
  localparam logic [3:0] c_OP_SUB = 4'b0110;
  localparam logic [3:0] c_OP_SLT = 4'b0111;
  localparam logic [3:0] c_OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BITS = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q,    state_d;
  logic [WIDTH-1:0]  a_sh_q,     a_sh_d;
  logic [WIDTH-1:0]  b_sh_q,     b_sh_d;
  logic [3:0]        op_q,       op_d;
  logic [c_CW-1:0]   cnt_q,      cnt_d;
  logic              carry_q,    carry_d;
  logic [WIDTH-1:0]  work_q,     work_d;
  logic              set_q,      set_d;
  logic [WIDTH-1:0]  result_q,   result_d;
  logic              zero_q,     zero_d;
  logic              overflow_q, overflow_d;

  // Slice control decode and the 1-bit slice itself
  logic              w_ainvert;
  logic              w_bnegate;
  logic [1:0]        w_operation;
  logic              w_supported;
  logic              w_is_addsub;
  logic              w_a_in;
  logic              w_b_in;
  logic              w_less;
  logic              w_sum;
  logic              w_cout;
  logic              w_bit;
  logic              w_ovf;
  logic              w_set;

  // Decode the latched opcode into slice controls and evaluate the slice
  always_comb begin
    w_ainvert   = 1'b0;
    w_bnegate   = 1'b0;
    w_operation = 2'b10;   // unknown codes run as ADD, result masked later
    w_supported = 1'b1;
    w_is_addsub = 1'b0;
    case (op_q)
      c_OP_AND: w_operation = 2'b00;
      c_OP_OR:  w_operation = 2'b01;
      c_OP_ADD: begin
        w_operation = 2'b10;
        w_is_addsub = 1'b1;
      end
      c_OP_SUB: begin
        w_bnegate   = 1'b1;
        w_operation = 2'b10;
        w_is_addsub = 1'b1;
      end
      c_OP_SLT: begin
        w_bnegate   = 1'b1;
        w_operation = 2'b11;
      end
      c_OP_NOR: begin
        w_ainvert   = 1'b1;
        w_bnegate   = 1'b1;
        w_operation = 2'b00;
      end
      default:  w_supported = 1'b0;
    endcase

    w_less = 1'b0;
    w_a_in = a_sh_q[0] ^ w_ainvert;
    w_b_in = b_sh_q[0] ^ w_bnegate;
    w_sum  = w_a_in ^ w_b_in ^ carry_q;
    w_cout = (w_a_in & w_b_in) | (w_a_in & carry_q) | (w_b_in & carry_q);

    case (w_operation)
      2'b00:   w_bit = w_a_in & w_b_in;
      2'b01:   w_bit = w_a_in | w_b_in;
      2'b10:   w_bit = w_sum;
      default: w_bit = w_less;
    endcase

    // Only meaningful on the MSB cycle
    w_ovf = carry_q ^ w_cout;
    w_set = w_sum ^ w_ovf;
  end

  // Next-state logic: sequencing, bit capture and output loading on DONE entry
  always_comb begin
    logic [WIDTH-1:0] final_v;
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    work_d     = work_q;
    set_d      = set_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    final_v    = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = alu_ctrl;
          cnt_d   = '0;
          carry_d = (alu_ctrl == c_OP_SUB) || (alu_ctrl == c_OP_SLT);
          state_d = S_BITS;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_BITS: begin
        // Result bits enter at the top and settle into place after WIDTH shifts
        final_v = {w_bit, work_q[WIDTH-1:1]};
        work_d  = final_v;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = w_cout;
        cnt_d   = cnt_q + c_CW'(1);
        if (cnt_q == c_LAST) begin
          set_d = w_set;
          if (op_q == c_OP_SLT) begin
            state_d = S_FIX;
          end else begin
            state_d    = S_DONE;
            result_d   = w_supported ? final_v : '0;
            zero_d     = (result_d == '0);
            overflow_d = w_is_addsub ? w_ovf : 1'b0;
          end
        end
      end

      S_FIX: begin
        final_v    = {{(WIDTH-1){1'b0}}, set_q};
        work_d     = final_v;
        state_d    = S_DONE;
        result_d   = final_v;
        zero_d     = (final_v == '0);
        overflow_d = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      work_q     <= '0;
      set_q      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      work_q     <= work_d;
      set_q      <= set_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy     = (state_q == S_BITS) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial_ctrl
// Purpose  : Self-checking bench for alu_serial_ctrl (WIDTH=8): directed
//            vectors with literal expectations plus a per-cycle comparison
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;

  localparam int W = 8;

  localparam logic [3:0] c_AND = 4'b0000;
  localparam logic [3:0] c_OR  = 4'b0001;
  localparam logic [3:0] c_ADD = 4'b0010;
  localparam logic [3:0] c_SUB = 4'b0110;
  localparam logic [3:0] c_SLT = 4'b0111;
  localparam logic [3:0] c_NOR = 4'b1100;
  localparam logic [3:0] c_BAD = 4'b0011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_ctrl = '0;
  logic         ready, busy, done, zero, overflow;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ready    (ready),
    .a        (a),
    .b        (b),
    .alu_ctrl (alu_ctrl),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the opcode definitions
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [3:0] op);
    case (op)
      c_AND:   return x & y;
      c_OR:    return x | y;
      c_ADD:   return x + y;
      c_SUB:   return x - y;
      c_SLT:   return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      c_NOR:   return ~(x | y);
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [3:0] op);
    logic [W-1:0] s;
    if (op == c_ADD) begin
      s = x + y;
      return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    end else if (op == c_SUB) begin
      s = x - y;
      return (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    end
    return 1'b0;
  endfunction

  // Transaction-level model: remaining cycles of the current operation
  int           m_remain;
  logic         m_done;
  logic [W-1:0] m_res, p_res;
  logic         m_zero, m_ovf, p_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_remain <= 0;
      m_done   <= 1'b0;
      m_res    <= '0;
      m_zero   <= 1'b0;
      m_ovf    <= 1'b0;
      p_res    <= '0;
      p_ovf    <= 1'b0;
    end else if (m_remain != 0) begin
      m_remain <= m_remain - 1;
      m_done   <= (m_remain == 1);
      if (m_remain == 1) begin
        m_res  <= p_res;
        m_zero <= (p_res == '0);
        m_ovf  <= p_ovf;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_remain <= (alu_ctrl == c_SLT) ? W + 1 : W;
        p_res    <= ref_result(a, b, alu_ctrl);
        p_ovf    <= ref_ovf(a, b, alu_ctrl);
      end
    end
  end

  // Every cycle out of reset, all outputs must match the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready",    32'(ready),    32'(m_remain == 0));
      chk("busy",     32'(busy),     32'(m_remain != 0));
      chk("done",     32'(done),     32'(m_done));
      chk("result",   32'(result),   32'(m_res));
      chk("zero",     32'(zero),     32'(m_zero));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // Issue one op at a negedge, wait (bounded) for done, check literals
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [3:0] tc, input logic [W-1:0] er, input logic ez,
                        input logic eo, input int elat);
    int n;
    a = ta; b = tb_v; alu_ctrl = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(n), 32'(elat));
    chk({nm, "_result"}, 32'(result), 32'(er));
    chk({nm, "_zero"}, 32'(zero), 32'(ez));
    chk({nm, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_ready",  32'(ready),  32'd1);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_zero",   32'(zero),   32'd0);
    chk("rst_ovf",    32'(overflow), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    run_op("add_ovf",  8'h7F, 8'h01, c_ADD, 8'h80, 1'b0, 1'b1, W);
    // Next ops start in the DONE cycle: back-to-back acceptance
    run_op("sub_eq",   8'h05, 8'h05, c_SUB, 8'h00, 1'b1, 1'b0, W);
    run_op("add_wrap", 8'hFF, 8'h01, c_ADD, 8'h00, 1'b1, 1'b0, W);
    run_op("slt_neg",  8'h80, 8'h01, c_SLT, 8'h01, 1'b0, 1'b0, W + 1);
    run_op("slt_fix",  8'h7F, 8'h80, c_SLT, 8'h00, 1'b1, 1'b0, W + 1);
    run_op("and",      8'hF0, 8'h3C, c_AND, 8'h30, 1'b0, 1'b0, W);
    run_op("or",       8'hF0, 8'h0F, c_OR,  8'hFF, 1'b0, 1'b0, W);
    run_op("nor",      8'hF0, 8'h0F, c_NOR, 8'h00, 1'b1, 1'b0, W);
    run_op("sub_ovf",  8'h80, 8'h01, c_SUB, 8'h7F, 1'b0, 1'b1, W);
    run_op("bad_op",   8'h01, 8'h02, c_BAD, 8'h00, 1'b1, 1'b0, W);
    @(negedge clk);  // one idle cycle
    run_op("and_idle", 8'hF0, 8'h3C, c_AND, 8'h30, 1'b0, 1'b0, W);
    @(negedge clk);

    // start held high with different operands during BITS is ignored
    a = 8'h12; b = 8'h34; alu_ctrl = c_ADD; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; alu_ctrl = c_OR;
    repeat (4) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("held_done",   32'(done),   32'd1);
    chk("held_result", 32'(result), 32'h46);
    chk("held_ovf",    32'(overflow), 32'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of an ADD
    a = 8'h10; b = 8'h20; alu_ctrl = c_ADD; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_result", 32'(result), 32'h46);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", 32'(result), 32'h0);
    chk("arst_ready",  32'(ready),  32'd1);
    chk("arst_busy",   32'(busy),   32'd0);
    chk("arst_done",   32'(done),   32'd0);
    chk("arst_zero",   32'(zero),   32'd0);
    chk("arst_ovf",    32'(overflow), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op("add_after_rst", 8'h11, 8'h22, c_ADD, 8'h33, 1'b0, 1'b0, W);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
